// File: rtl/gnn_mac_sequencer.sv
// Control sequencer that schedules both GNN dense layers onto one shared MAC datapath.
// Optional GNN_SEQ_HOLD_EN adds a hold input that stalls the schedule mid-run.
module gnn_mac_sequencer #(
    parameter int NUM_NODES = 4,
    parameter int NUM_IN    = 4,
    parameter int NUM_HID   = 4,
    parameter int NUM_OUT   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef GNN_SEQ_HOLD_EN
    input  logic                         hold,
`endif
    input  logic                         in_ready,
    output logic                         busy,
    output logic                         layer,
    output logic [1:0]                   node_idx,
    output logic [1:0]                   neuron_idx,
    output logic [1:0]                   op_idx,
    output logic                         mac_en,
    output logic                         mac_clear,
    output logic                         hid_wr,
    output logic                         out_wr,
    output logic [NUM_NODES*NUM_OUT-1:0] out_ready,
    output logic                         done
);

    typedef enum logic [2:0] {
        IDLE,
        L1_MAC,
        L1_WB,
        L2_MAC,
        L2_WB,
        DONE
    } state_t;

    localparam int OW = $clog2(NUM_NODES * NUM_OUT);
    localparam logic [1:0] LAST_IN   = 2'(NUM_IN - 1);
    localparam logic [1:0] LAST_HID  = 2'(NUM_HID - 1);
    localparam logic [1:0] LAST_OUT  = 2'(NUM_OUT - 1);
    localparam logic [1:0] LAST_NODE = 2'(NUM_NODES - 1);

    state_t        state;
    state_t        nxt_state;
    logic [1:0]    nxt_node;
    logic [1:0]    nxt_neuron;
    logic [1:0]    nxt_op;
    logic          start_accept;
    logic          stall;
    logic          mac_en_q;
    logic          mac_clear_q;
    logic          hid_wr_q;
    logic          out_wr_q;
    logic [OW-1:0] out_sel;

`ifdef GNN_SEQ_HOLD_EN
    assign stall = hold & busy;
`else
    assign stall = 1'b0;
`endif

    // Strobes are masked in the same cycle hold is seen so the pending op is replayed later.
    assign mac_en    = mac_en_q & ~stall;
    assign mac_clear = mac_clear_q & ~stall;
    assign hid_wr    = hid_wr_q & ~stall;
    assign out_wr    = out_wr_q & ~stall;

    assign out_sel = OW'(node_idx) * OW'(NUM_OUT) + OW'(neuron_idx);

    always_comb begin
        nxt_state    = state;
        nxt_node     = node_idx;
        nxt_neuron   = neuron_idx;
        nxt_op       = op_idx;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (in_ready) begin
                    nxt_state    = L1_MAC;
                    nxt_node     = 2'd0;
                    nxt_neuron   = 2'd0;
                    nxt_op       = 2'd0;
                    start_accept = 1'b1;
                end
            end
            L1_MAC, L2_MAC: begin
                if (op_idx == ((state == L1_MAC) ? LAST_IN : LAST_HID)) begin
                    nxt_op    = 2'd0;
                    nxt_state = (state == L1_MAC) ? L1_WB : L2_WB;
                end else begin
                    nxt_op = op_idx + 2'd1;
                end
            end
            L1_WB, L2_WB: begin
                // Neuron-major inside a node; the last node of layer 1 hands over to layer 2.
                if (neuron_idx == ((state == L1_WB) ? LAST_HID : LAST_OUT)) begin
                    nxt_neuron = 2'd0;
                    if (node_idx == LAST_NODE) begin
                        nxt_node  = 2'd0;
                        nxt_state = (state == L1_WB) ? L2_MAC : DONE;
                    end else begin
                        nxt_node  = node_idx + 2'd1;
                        nxt_state = (state == L1_WB) ? L1_MAC : L2_MAC;
                    end
                end else begin
                    nxt_neuron = neuron_idx + 2'd1;
                    nxt_state  = (state == L1_WB) ? L1_MAC : L2_MAC;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            node_idx    <= 2'd0;
            neuron_idx  <= 2'd0;
            op_idx      <= 2'd0;
            busy        <= 1'b0;
            layer       <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            hid_wr_q    <= 1'b0;
            out_wr_q    <= 1'b0;
            done        <= 1'b0;
            out_ready   <= '0;
        end else if (!stall) begin
            state       <= nxt_state;
            node_idx    <= nxt_node;
            neuron_idx  <= nxt_neuron;
            op_idx      <= nxt_op;
            busy        <= (nxt_state == L1_MAC) || (nxt_state == L1_WB) ||
                           (nxt_state == L2_MAC) || (nxt_state == L2_WB);
            layer       <= (nxt_state == L2_MAC) || (nxt_state == L2_WB);
            mac_en_q    <= (nxt_state == L1_MAC) || (nxt_state == L2_MAC);
            mac_clear_q <= ((nxt_state == L1_MAC) || (nxt_state == L2_MAC)) && (nxt_op == 2'd0);
            hid_wr_q    <= (nxt_state == L1_WB);
            out_wr_q    <= (nxt_state == L2_WB);
            done        <= (nxt_state == DONE);
            if (start_accept) begin
                out_ready <= '0;
            end else if (out_wr_q) begin
                out_ready[out_sel] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gnn_mac_sequencer.sv
// Directed self-checking bench for gnn_mac_sequencer: full runs, restart, resets, out_ready map.
// With GNN_SEQ_HOLD_EN defined it also exercises the hold stall.
module tb_gnn_mac_sequencer;

    logic       clk;
    logic       rst;
    logic       in_ready;
    logic       busy;
    logic       layer;
    logic [1:0] node_idx;
    logic [1:0] neuron_idx;
    logic [1:0] op_idx;
    logic       mac_en;
    logic       mac_clear;
    logic       hid_wr;
    logic       out_wr;
    logic [7:0] out_ready;
    logic       done;
`ifdef GNN_SEQ_HOLD_EN
    logic       hold;
`endif

    int errors = 0;
    int checks = 0;

    gnn_mac_sequencer dut (
        .clk        (clk),
        .rst        (rst),
`ifdef GNN_SEQ_HOLD_EN
        .hold       (hold),
`endif
        .in_ready   (in_ready),
        .busy       (busy),
        .layer      (layer),
        .node_idx   (node_idx),
        .neuron_idx (neuron_idx),
        .op_idx     (op_idx),
        .mac_en     (mac_en),
        .mac_clear  (mac_clear),
        .hid_wr     (hid_wr),
        .out_wr     (out_wr),
        .out_ready  (out_ready),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [20:0] dut_vec = {busy, layer, node_idx, neuron_idx, op_idx,
                           mac_en, mac_clear, hid_wr, out_wr, done, out_ready};

    // Expected output vector for cycle c counted from a start accepted at edge 0.
    function automatic logic [20:0] exp_vec(input int c);
        logic       b, l, me, mc, hw, ow, d;
        logic [1:0] n, u, o;
        logic [7:0] r;
        int         i, ph;
        {b, l, me, mc, hw, ow, d} = '0;
        n = 2'd0; u = 2'd0; o = 2'd0; r = 8'd0;
        if (c >= 1 && c <= 120) begin
            b  = 1'b1;
            i  = (c - 1) / 5;
            ph = (c - 1) % 5;
            if (i < 16) begin
                n = 2'(i / 4);
                u = 2'(i % 4);
            end else begin
                l = 1'b1;
                n = 2'((i - 16) / 2);
                u = 2'((i - 16) % 2);
            end
            if (ph < 4) begin
                me = 1'b1;
                o  = 2'(ph);
                mc = (ph == 0);
            end else if (i < 16) begin
                hw = 1'b1;
            end else begin
                ow = 1'b1;
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (85 + 5 * j < c) r[j] = 1'b1;
        end
        if (c == 121) d = 1'b1;
        return {b, l, n, u, o, me, mc, hw, ow, d, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive inputs, then move to the next cycle and sample 1ns after the edge.
    task automatic applyStimulus(input logic start, input logic reset_v);
        in_ready = start;
        rst      = reset_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_ready = 1'b0;
`ifdef GNN_SEQ_HOLD_EN
        hold     = 1'b0;
`endif
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset_state", 32'(dut_vec), 32'd0);

        // Run 1: start pulse, then in_ready toggles during the run and in DONE.
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 122; c++) begin
            checkOutput($sformatf("run1_c%0d", c), 32'(dut_vec), 32'(exp_vec(c)));
            if (c == 1) checkOutput("first_mac", 32'({mac_en, mac_clear, layer}), 32'b110);
            if (c == 5) checkOutput("first_hid_wr", 32'({hid_wr, mac_en}), 32'b10);
            if (c == 110) checkOutput("out_wr_n2_o1", 32'({out_wr, node_idx, neuron_idx, out_ready}),
                                      32'({1'b1, 2'd2, 2'd1, 8'h1F}));
            if (c == 111) checkOutput("out_ready_bit5", 32'(out_ready), 32'h3F);
            if (c == 121) checkOutput("done_all_ready", 32'({done, busy, out_ready}), 32'({1'b1, 1'b0, 8'hFF}));
            applyStimulus((c <= 121) ? ((c % 2) == 1) : 1'b0, 1'b0);
        end
        checkOutput("idle_holds_ready", 32'(dut_vec), 32'(exp_vec(123)));

        // Run 2: in_ready held high, restart lands at cycle 123.
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 122; c++) begin
            checkOutput($sformatf("run2_c%0d", c), 32'(dut_vec), 32'(exp_vec(c)));
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("run2_restart_c123", 32'(dut_vec), 32'(exp_vec(1)));

        // Reset at cycle 40 of that third run, then restart at cycle 45.
        for (int c = 1; c < 40; c++) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_rst_c40", 32'(dut_vec), 32'(exp_vec(40)));
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst_mid_l1_c41", 32'(dut_vec), 32'd0);
        for (int c = 41; c < 45; c++) applyStimulus(1'b0, 1'b0);
        checkOutput("idle_c45", 32'(dut_vec), 32'd0);
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            checkOutput($sformatf("replay_k%0d", k), 32'(dut_vec), 32'(exp_vec(k)));
            if (k < 100) applyStimulus(1'b0, 1'b0);
        end

        // Reset during layer 2 must also drop the partial out_ready flags.
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst_mid_l2", 32'(dut_vec), 32'd0);
        applyStimulus(1'b0, 1'b0);

`ifdef GNN_SEQ_HOLD_EN
        begin
            int done_cycle;
            done_cycle = 0;
            applyStimulus(1'b1, 1'b0);
            for (int c = 1; c <= 130; c++) begin
                hold = (c >= 3 && c <= 6);
                #1;
                if (c >= 3 && c <= 6) begin
                    checkOutput($sformatf("hold_strobes_c%0d", c), 32'({mac_en, mac_clear, hid_wr, out_wr}), 32'd0);
                    checkOutput($sformatf("hold_busy_op_c%0d", c), 32'({busy, op_idx}), 32'({1'b1, 2'd2}));
                end
                if (c == 7) checkOutput("hold_resume_op2", 32'({mac_en, op_idx}), 32'({1'b1, 2'd2}));
                if (c == 8) checkOutput("hold_no_early_wr", 32'({hid_wr, op_idx}), 32'({1'b0, 2'd3}));
                if (c == 9) checkOutput("hold_hid_wr_c9", 32'(hid_wr), 32'd1);
                if (done && done_cycle == 0) done_cycle = c;
                applyStimulus(1'b0, 1'b0);
            end
            hold = 1'b0;
            checkOutput("hold_done_cycle", 32'(done_cycle), 32'd125);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
